// File: rtl/wb_agu_pkg.sv
// Shared definitions for the read/write address generators.
//   state_t       : transfer FSM encoding (IDLE / RUN / DONE)
//   AGU_BWADDR    : default write-address / jump width
//   AGU_BWLENGTH  : default loop-length counter width
package wb_agu_pkg;

  localparam int unsigned AGU_BWADDR   = 21;
  localparam int unsigned AGU_BWLENGTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wb_agu_loopnest.sv
// 4-level nested-loop address core.
//   clk, rst_n        : clock / async active-low reset
//   load              : latch base, lengths and jumps; reload counters
//   step              : advance one beat (ignored on the last beat)
//   base, l0..l3      : start address and per-level lengths (iterations = lN+1)
//   j0..j3            : per-level address jumps (two's complement)
//   addr              : current address
//   last              : all counters are zero, i.e. current beat is the final one
module agu_loopnest
  import wb_agu_pkg::*;
#(
  parameter int unsigned BWADDR   = AGU_BWADDR,
  parameter int unsigned BWLENGTH = AGU_BWLENGTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic [BWADDR-1:0]   base,
  input  logic [BWLENGTH-1:0] l0,
  input  logic [BWLENGTH-1:0] l1,
  input  logic [BWLENGTH-1:0] l2,
  input  logic [BWLENGTH-1:0] l3,
  input  logic [BWADDR-1:0]   j0,
  input  logic [BWADDR-1:0]   j1,
  input  logic [BWADDR-1:0]   j2,
  input  logic [BWADDR-1:0]   j3,
  output logic [BWADDR-1:0]   addr,
  output logic                last
);

  logic [BWADDR-1:0]   r_addr;
  logic [BWLENGTH-1:0] r_i0, r_i1, r_i2, r_i3;
  logic [BWLENGTH-1:0] r_l0, r_l1, r_l2;
  logic [BWADDR-1:0]   r_j0, r_j1, r_j2, r_j3;
  logic                w_z0, w_z1, w_z2, w_z3;

  assign w_z0 = (r_i0 == '0);
  assign w_z1 = (r_i1 == '0);
  assign w_z2 = (r_i2 == '0);
  assign w_z3 = (r_i3 == '0);
  assign last = w_z0 & w_z1 & w_z2 & w_z3;
  assign addr = r_addr;

  // Level 3 has no reload (it terminates the nest), so l3 only seeds r_i3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_i0   <= '0;
      r_i1   <= '0;
      r_i2   <= '0;
      r_i3   <= '0;
      r_l0   <= '0;
      r_l1   <= '0;
      r_l2   <= '0;
      r_j0   <= '0;
      r_j1   <= '0;
      r_j2   <= '0;
      r_j3   <= '0;
    end else if (load) begin
      r_addr <= base;
      r_i0   <= l0;
      r_i1   <= l1;
      r_i2   <= l2;
      r_i3   <= l3;
      r_l0   <= l0;
      r_l1   <= l1;
      r_l2   <= l2;
      r_j0   <= j0;
      r_j1   <= j1;
      r_j2   <= j2;
      r_j3   <= j3;
    end else if (step && !last) begin
      if (w_z0 && w_z1 && w_z2) begin
        r_addr <= r_addr + r_j3;
        r_i0   <= r_l0;
        r_i1   <= r_l1;
        r_i2   <= r_l2;
        r_i3   <= r_i3 - 1'b1;
      end else if (w_z0 && w_z1) begin
        r_addr <= r_addr + r_j2;
        r_i0   <= r_l0;
        r_i1   <= r_l1;
        r_i2   <= r_i2 - 1'b1;
      end else if (w_z0) begin
        r_addr <= r_addr + r_j1;
        r_i0   <= r_l0;
        r_i1   <= r_i1 - 1'b1;
      end else begin
        r_addr <= r_addr + r_j0;
        r_i0   <= r_i0 - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_agu.sv
// Write-back address generator: accepts result words over valid/ready and
// emits registered memory write strobes at nested-loop addresses.
//   clk, rst_n          : clock / async active-low reset
//   start               : latch config and begin a transfer (IDLE only)
//   base, l0..l3, j0..j3: loop-nest configuration
//   in_valid/in_data    : result stream; in_ready high while running
//   wr_en/wr_addr/wr_data: memory write port (one cycle after accept)
//   busy                : transfer in progress
//   done                : one-cycle pulse coinciding with the final write
module wb_agu
  import wb_agu_pkg::*;
#(
  parameter int unsigned BWADDR   = AGU_BWADDR,
  parameter int unsigned BWLENGTH = AGU_BWLENGTH,
  parameter int unsigned BWDATA   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BWADDR-1:0]   base,
  input  logic [BWLENGTH-1:0] l0,
  input  logic [BWLENGTH-1:0] l1,
  input  logic [BWLENGTH-1:0] l2,
  input  logic [BWLENGTH-1:0] l3,
  input  logic [BWADDR-1:0]   j0,
  input  logic [BWADDR-1:0]   j1,
  input  logic [BWADDR-1:0]   j2,
  input  logic [BWADDR-1:0]   j3,
  input  logic                in_valid,
  input  logic [BWDATA-1:0]   in_data,
  output logic                in_ready,
  output logic                wr_en,
  output logic [BWADDR-1:0]   wr_addr,
  output logic [BWDATA-1:0]   wr_data,
  output logic                busy,
  output logic                done
);

  state_t              r_state;
  logic                r_wr_en;
  logic [BWADDR-1:0]   r_wr_addr;
  logic [BWDATA-1:0]   r_wr_data;
  logic                w_run;
  logic                w_accept;
  logic                w_load;
  logic [BWADDR-1:0]   w_addr;
  logic                w_last;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = in_valid & w_run;
  assign w_load   = start & (r_state == ST_IDLE);

  agu_loopnest #(
    .BWADDR  (BWADDR),
    .BWLENGTH(BWLENGTH)
  ) u_loopnest (
    .clk  (clk),
    .rst_n(rst_n),
    .load (w_load),
    .step (w_accept),
    .base (base),
    .l0   (l0),
    .l1   (l1),
    .l2   (l2),
    .l3   (l3),
    .j0   (j0),
    .j1   (j1),
    .j2   (j2),
    .j3   (j3),
    .addr (w_addr),
    .last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= w_addr;
        r_wr_data <= in_data;
      end
      case (r_state)
        ST_IDLE: if (start) r_state <= ST_RUN;
        ST_RUN:  if (w_accept && w_last) r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = w_run;
  assign busy     = w_run;
  assign done     = (r_state == ST_DONE);
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule

// File: doc/wb_agu.md
Name: wb_agu

Overview:
Write-back address generator. It is the writer-side counterpart of the read AGU: it accepts a stream of result words over a valid/ready handshake and emits memory write strobes. Write addresses are produced by the same 4-level nested-loop jump scheme used by the read side (per-level lengths l0..l2, jumps j0..j3). A finite outer count l3 lets the block terminate and signal done. It sits between the MVU result path and the output/activation RAM write port.

Parameters:
BWADDR, 21, bitwidth of write address and jump values
BWLENGTH, 8, bitwidth of loop length counters
BWDATA, 64, bitwidth of result data word

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; latches config and begins a transfer (honoured only in IDLE)
base  input  BWADDR  first write address
l0  input  BWLENGTH  loop length, level 0 (iterations = l0+1)
l1  input  BWLENGTH  loop length, level 1
l2  input  BWLENGTH  loop length, level 2
l3  input  BWLENGTH  outer count, level 3
j0  input  BWADDR  address jump, level 0
j1  input  BWADDR  address jump, level 1
j2  input  BWADDR  address jump, level 2
j3  input  BWADDR  address jump, level 3
in_valid  input  1  result word valid
in_data  input  BWDATA  result word
in_ready  output  1  block accepts in_data this cycle
wr_en  output  1  memory write strobe
wr_addr  output  BWADDR  memory write address
wr_data  output  BWDATA  memory write data
busy  output  1  transfer in progress
done  output  1  one-cycle pulse on the final write

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; in_ready, wr_en, busy and done are 0; wr_addr and wr_data are 0; counters i0..i3 and addr are 0. Reset mid-transfer aborts the transfer. No write is issued after reset.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch l0..l3 and j0..j3; load addr<=base and i0..i3<=l0..l3; go to RUN. The config inputs are don't-care after this cycle.
- RUN: busy=1 and in_ready=1. The write port never stalls, so there is no backpressure. start is ignored.
- Accept = in_valid & in_ready. On accept at cycle t:
  - at t+1: wr_en=1, wr_addr=addr, wr_data=in_data.
  - The address and counters advance as follows (zN = iN==0):
    - z0&z1&z2&z3: last beat; go to DONE; addr is not updated.
    - z0&z1&z2: addr+=j3; i0..i2 reload from l0..l2; i3-=1.
    - z0&z1: addr+=j2; i0,i1 reload; i2-=1.
    - z0: addr+=j1; i0 reload; i1-=1.
    - else: addr+=j0; i0-=1.
- No accept: wr_en=0 the next cycle; state and counters hold.
- Total beats = (l0+1)(l1+1)(l2+1)(l3+1). All lengths 0 gives exactly one write.
- Arithmetic: address addition is modulo 2^BWADDR. Jumps are interpreted as two's complement, so negative strides wrap naturally. Counters never underflow because they are reloaded at zero.
- DONE: lasts exactly one cycle, coinciding with the final wr_en; done=1, busy=0, in_ready=0. Next state is IDLE. A start pulse in DONE is ignored.
- wr_en is registered and held for one cycle per accepted beat. Back-to-back accepts give a contiguous wr_en.
- wr_addr and wr_data hold their last values when wr_en=0.

Decomposition:
- Shared package: state enum (IDLE/RUN/DONE) and the BWADDR/BWLENGTH defaults shared with the read AGU.
- One natural sub-module, agu_loopnest: the 4-level counter and address-bump core with inputs load and step, and outputs addr and last. Keeping it separate lets the read path reuse it later.

Test Plan:
- Single beat: base=0x40, l0..l3=0, one accept -> one wr_en, wr_addr=0x40, done pulse in the same cycle as wr_en, busy returns to 0.
- 2-D walk: base=100, l0=1, l1=1, l2=l3=0, j0=1, j1=9; 4 accepts back-to-back -> wr_addr sequence 100, 101, 110, 111 with wr_data matching input order; done on the 4th write.
- Stalled input: same config, with in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 writes, each one cycle after its accept; no extra strobes.
- Negative jump/wrap: base=2, l0=2, j0=0x1FFFFF (-1) -> addresses 2, 1, 0, then the sequence continues modulo 2^21 as configured. With base=0, l0=1, j0=-1 -> addresses 0, 0x1FFFFF.
- Reset mid-transfer: drop rst_n after 2 of 4 beats -> wr_en, busy and done go to 0 immediately. After release, a new start runs a full fresh sequence from the new base.
- start ignored while busy: pulse start with a different base during RUN -> the sequence is unchanged and the total write count equals the original config.
